muldiv_iter: RTL and testbench

- Parametrised iterative RV32M/RV64M multiply/divide unit; next generation of the ALU's multicycle mul/div path.
- Covers all eight M-extension ops, including MULH/MULHSU/MULHU upper halves, through one shared shift-add / restoring-divide datapath.
- Configurable width and bits-per-cycle; valid/ready handshake on both sides; kill input and tag passthrough.
- Instantiated by the ALU, which hands off M-extension ops and stalls until the response.

---
 rtl/muldiv_iter.sv | 217 +++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
`timescale 1ns/1ps
// muldiv_iter: iterative RV32M/RV64M multiply/divide unit.
// A single shared datapath does shift-add multiply and restoring divide, retiring
// BITS_PER_CYCLE bits per CALC cycle.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a
// combinational multiplier. Divides always use the iterative path.
module muldiv_iter #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int TAG_W          = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [XLEN-1:0]  req_rs1,
   input  logic [XLEN-1:0]  req_rs2,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             kill,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_result,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy
);

   localparam int N     = XLEN / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST_MUL = 1'b1;
`else
   localparam bit FAST_MUL = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   // op and correction flags captured at accept
   typedef struct packed {
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
      logic             neg;    // negate product / quotient
      logic             neg_r;  // negate remainder (dividend sign)
   } req_t;

   state_t           state, state_nxt;
   req_t             req_q;
   logic [CNT_W-1:0] cnt;
   // shared registers: mul -> {acc_hi,acc_lo}=partial product, opd=multiplicand
   //                   div -> acc_hi=partial remainder, acc_lo=dividend/quotient, opd=divisor
   logic [XLEN-1:0]  acc_hi, acc_lo, opd;

   logic             s1, s2, sgn1, sgn2;
   logic [XLEN-1:0]  mag1, mag2;
   logic             spec_hit;
   logic [XLEN-1:0]  spec_res;
   logic             fast_go;
   logic [XLEN-1:0]  fast_res;
   logic [XLEN-1:0]  hi_nxt, lo_nxt;
   logic [XLEN:0]    rem_t;
   logic [XLEN+BITS_PER_CYCLE-1:0] sum_t;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]  quo, rem, fix_res;

   // operand signedness and magnitudes at the request port
   always_comb begin
      s1   = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
      s2   = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
      sgn1 = s1 & req_rs1[XLEN-1];
      sgn2 = s2 & req_rs2[XLEN-1];
      mag1 = sgn1 ? -req_rs1 : req_rs1;
      mag2 = sgn2 ? -req_rs2 : req_rs2;
   end

   // divide-by-zero and signed-overflow results, resolved without iterating
   always_comb begin
      spec_hit = 1'b0;
      spec_res = '0;
      if (req_op[2]) begin
         if (req_rs2 == '0) begin
            spec_hit = 1'b1;
            spec_res = req_op[1] ? req_rs1 : '1;
         end else if (!req_op[0] && req_rs1 == MOST_NEG && req_rs2 == '1) begin
            spec_hit = 1'b1;
            spec_res = req_op[1] ? '0 : req_rs1;
         end
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     fa, fb;
   logic signed [2*XLEN-1:0] fp;
   // single-cycle signed multiply on sign-or-zero-extended operands
   always_comb begin
      fa = {sgn1, req_rs1};
      fb = {sgn2, req_rs2};
      fp = $signed({{(XLEN-1){fa[XLEN]}}, fa}) * $signed({{(XLEN-1){fb[XLEN]}}, fb});
      fast_go  = !req_op[2];
      fast_res = (req_op == 3'd0) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
   end
`else
   // no hardware multiplier in this build
   always_comb begin
      fast_go  = 1'b0;
      fast_res = '0;
   end
`endif

   // one CALC iteration: BITS_PER_CYCLE steps of shift-add or restoring divide
   always_comb begin
      hi_nxt = acc_hi;
      lo_nxt = acc_lo;
      rem_t  = '0;
      sum_t  = '0;
      if (req_q.op[2]) begin
         for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_t  = {hi_nxt, lo_nxt[XLEN-1]};
            lo_nxt = {lo_nxt[XLEN-2:0], 1'b0};
            if (rem_t >= {1'b0, opd}) begin
               rem_t     = rem_t - {1'b0, opd};
               lo_nxt[0] = 1'b1;
            end
            hi_nxt = rem_t[XLEN-1:0];
         end
      end else begin
         sum_t = {{BITS_PER_CYCLE{1'b0}}, acc_hi};
         for (int i = 0; i < BITS_PER_CYCLE; i++)
            if (acc_lo[i]) sum_t = sum_t + ({{BITS_PER_CYCLE{1'b0}}, opd} << i);
         {hi_nxt, lo_nxt} = {sum_t, acc_lo[XLEN-1:BITS_PER_CYCLE]};
      end
   end

   // sign correction and result selection used in FIXUP
   always_comb begin
      prod = {acc_hi, acc_lo};
      if (req_q.neg) prod = -prod;
      quo = req_q.neg   ? -acc_lo : acc_lo;
      rem = req_q.neg_r ? -acc_hi : acc_hi;
      case (req_q.op)
         3'd0:                fix_res = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    fix_res = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:          fix_res = quo;
         default:             fix_res = rem;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic; kill overrides everything
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = (spec_hit || (FAST_MUL && fast_go)) ? DONE : CALC;
         CALC:    if (cnt == '0) state_nxt = FIXUP;
         FIXUP:   state_nxt = DONE;
         DONE:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (kill) state_nxt = IDLE;
   end

   // state-decoded outputs
   always_comb begin
      req_ready = (state == IDLE);
      busy      = (state != IDLE);
   end

   // datapath and registered response; nothing is loaded in a kill cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q       <= '0;
         cnt         <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         opd         <= '0;
         resp_valid  <= 1'b0;
         resp_result <= '0;
         resp_tag    <= '0;
      end else begin
         resp_valid <= (state_nxt == DONE);
         if (!kill) begin
            case (state)
               IDLE: if (req_valid) begin
                  req_q  <= '{op: req_op, tag: req_tag, neg: sgn1 ^ sgn2, neg_r: sgn1};
                  cnt    <= CNT_W'(N - 1);
                  acc_hi <= '0;
                  acc_lo <= req_op[2] ? mag1 : mag2;
                  opd    <= req_op[2] ? mag2 : mag1;
                  if (spec_hit) begin
                     resp_result <= spec_res;
                     resp_tag    <= req_tag;
                  end else if (FAST_MUL && fast_go) begin
                     resp_result <= fast_res;
                     resp_tag    <= req_tag;
                  end
               end
               CALC: begin
                  acc_hi <= hi_nxt;
                  acc_lo <= lo_nxt;
                  cnt    <= cnt - 1'b1;
               end
               FIXUP: begin
                  resp_result <= fix_res;
                  resp_tag    <= req_q.tag;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
`timescale 1ns/1ps
// tb_muldiv_iter: randomized and directed checks of muldiv_iter against an
// arithmetic reference model (RISC-V M-extension semantics).
module tb_muldiv_iter;
   parameter int BPC = 1;
   localparam int XLEN  = 32;
   localparam int TAG_W = 5;
   localparam int N     = XLEN / BPC;
`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid, req_ready;
   logic [2:0]       req_op;
   logic [XLEN-1:0]  req_rs1, req_rs2;
   logic [TAG_W-1:0] req_tag;
   logic             kill;
   logic             resp_valid, resp_ready;
   logic [XLEN-1:0]  resp_result;
   logic [TAG_W-1:0] resp_tag;
   logic             busy;

   int n_chk  = 0;
   int n_fail = 0;

   muldiv_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
      .kill(kill),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_tag(resp_tag),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference result from the ISA definition
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub, p;
      logic [63:0] up;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      ia = $signed(a);
      ib = $signed(b);
      up = {32'b0, a} * {32'b0, b};
      case (op)
         3'd0: return up[31:0];
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: return up[63:32];
         3'd4: if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
               else return 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
               else return 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // expected edges from accept (accept edge = 1) until resp_valid is seen
   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
      if (!op[2] && FAST) return 1;
      return N + 2;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // present a request, wait for the response, check it, optionally stall, then consume
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold);
      int          lat;
      logic [31:0] er;
      er = ref_res(op, a, b);
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
      req_tag = 5'($urandom);
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat(op, a, b)));
      chk($sformatf("result op%0d %h %h", op, a, b), resp_result, er);
      chk("tag", resp_tag, tag);
      chk("req_ready_done", req_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", resp_valid, 1'b1);
         chk("hold_result", resp_result, er);
         chk("hold_tag", resp_tag, tag);
         chk("hold_req_ready", req_ready, 1'b0);
      end
      @(negedge clk) resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("release_valid", resp_valid, 1'b0);
      chk("release_req_ready", req_ready, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
      kill = 1'b0; resp_ready = 1'b0;
      #12;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_result", resp_result, 0);
      chk("rst_resp_tag", resp_tag, 0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk) rst = 1'b0;

      // directed cases
      do_op(3'd5, 32'd100, 32'd7, 5'd3, 0);
      do_op(3'd7, 32'd100, 32'd7, 5'd4, 0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
      do_op(3'd4, 32'h1234_5678, 32'd0, 5'd7, 0);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
      do_op(3'd7, 32'hDEAD_BEEF, 32'd0, 5'd10, 0);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11, 0);
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 0);
      do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 5);

      // kill in the 5th CALC cycle of a DIVU
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd5; req_rs1 = 32'd1000; req_rs2 = 32'd9; req_tag = 5'd20;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk) kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill_resp_valid", resp_valid, 1'b0);
      chk("kill_req_ready", req_ready, 1'b1);
      chk("kill_busy", busy, 1'b0);
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (resp_valid) seen++; end
      chk("kill_no_resp", 64'(seen), 0);
      do_op(3'd5, 32'd9, 32'd3, 5'd21, 0);

      // request offered together with kill is dropped
      @(negedge clk);
      req_valid = 1'b1; kill = 1'b1; req_op = 3'd5; req_rs1 = 32'd5; req_rs2 = 32'd0;
      @(posedge clk); #1;
      req_valid = 1'b0; kill = 1'b0;
      chk("kill_accept_busy", busy, 1'b0);
      chk("kill_accept_valid", resp_valid, 1'b0);

      // reset in the middle of CALC
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd4; req_rs1 = 32'd777; req_rs2 = 32'd5; req_tag = 5'd30;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_req_ready", req_ready, 1'b1);
      chk("midrst_resp_valid", resp_valid, 1'b0);
      chk("midrst_resp_result", resp_result, 0);
      chk("midrst_resp_tag", resp_tag, 0);
      chk("midrst_busy", busy, 1'b0);
      @(negedge clk) rst = 1'b0;

      // randomized traffic
      for (int k = 0; k < 200; k++)
         do_op(3'($urandom), pick(), pick(), 5'($urandom), $urandom_range(0, 2));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
